// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for the shared CPU bus (16 drivers).
// Registers holder index and one-hot enable, with hold limit and turnaround gap.
module bus_rr_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] req,
    output logic [3:0]  grant_idx,
    output logic [15:0] grant_onehot,
    output logic        grant_valid,
    output logic        turnaround
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  last_q, last_d;
    logic [3:0]  hold_q, hold_d;
    logic [15:0] onehot_q, onehot_d;
    logic        valid_q, valid_d;
    logic        ta_q, ta_d;

    logic        found;
    logic [3:0]  pick;
    logic [3:0]  cand;
    logic        hold_done;

    // Scan starts one past the last holder; offset 16 wraps back to it.
    always_comb begin
        found = 1'b0;
        pick  = 4'd0;
        cand  = 4'd0;
        for (int k = 1; k <= 16; k++) begin
            cand = last_q + 4'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign hold_done = (hold_q == 4'(HOLD_MAX - 1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        hold_d   = hold_q;
        onehot_d = 16'h0000;
        valid_d  = 1'b0;
        ta_d     = 1'b0;
        unique case (state_q)
            IDLE, GAP: begin
                if (found) begin
                    state_d  = GRANT;
                    idx_d    = pick;
                    last_d   = pick;
                    hold_d   = 4'd0;
                    valid_d  = 1'b1;
                    onehot_d = 16'h0001 << pick;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!req[idx_q] || hold_done) begin
                    state_d = GAP;
                    ta_d    = 1'b1;
                end else begin
                    hold_d   = hold_q + 4'd1;
                    valid_d  = 1'b1;
                    onehot_d = 16'h0001 << idx_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            last_q   <= 4'd15;
            hold_q   <= 4'd0;
            onehot_q <= 16'h0000;
            valid_q  <= 1'b0;
            ta_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            ta_q     <= ta_d;
        end
    end

    assign grant_idx    = idx_q;
    assign grant_onehot = onehot_q;
    assign grant_valid  = valid_q;
    assign turnaround   = ta_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed testbench for bus_rr_arbiter (HOLD_MAX=4).
// Each scenario task drives req and checks registered outputs inline.
module tb_bus_rr_arbiter;

    logic        clk;
    logic        clr;
    logic [15:0] req;
    logic [3:0]  grant_idx;
    logic [15:0] grant_onehot;
    logic        grant_valid;
    logic        turnaround;

    int pass_cnt = 0;
    int total_cnt = 0;

    bus_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk          (clk),
        .clr          (clr),
        .req          (req),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .grant_valid  (grant_valid),
        .turnaround   (turnaround)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Invariants sampled every falling edge.
    always @(negedge clk) begin
        total_cnt++;
        if (!$onehot0(grant_onehot)) begin
            $display("FAIL inv_onehot0 got=%h", grant_onehot);
        end else begin
            pass_cnt++;
        end
        total_cnt++;
        if (grant_valid && turnaround) begin
            $display("FAIL inv_valid_ta valid=%b ta=%b", grant_valid, turnaround);
        end else begin
            pass_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 16'h0000;
        @(posedge clk);
        #1;
        clr = 1'b1;
        #2;
        clr = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        clr = 1'b1;
        req = 16'h0000;
        tick();
        tick();
        total_cnt++;
        if ({grant_valid, turnaround, grant_onehot, grant_idx} !== 22'd0) begin
            $display("FAIL reset_vals got v=%b t=%b oh=%h idx=%0d",
                     grant_valid, turnaround, grant_onehot, grant_idx);
        end else begin
            pass_cnt++;
        end
        clr = 1'b0;
        req = 16'h0020;
        tick();
        tick();
        total_cnt++;
        if (!(grant_valid === 1'b1 && grant_idx === 4'd5)) begin
            $display("FAIL reset_pre_grant got v=%b idx=%0d want v=1 idx=5",
                     grant_valid, grant_idx);
        end else begin
            pass_cnt++;
        end
        #2;
        clr = 1'b1;
        #1;
        total_cnt++;
        if ({grant_valid, turnaround, grant_onehot, grant_idx} !== 22'd0) begin
            $display("FAIL reset_async got v=%b t=%b oh=%h idx=%0d want all 0",
                     grant_valid, turnaround, grant_onehot, grant_idx);
        end else begin
            pass_cnt++;
        end
        req = 16'hFFFF;
        clr = 1'b0;
        tick();
        total_cnt++;
        if (!(grant_valid === 1'b1 && grant_idx === 4'd0 &&
              grant_onehot === 16'h0001)) begin
            $display("FAIL reset_prio got v=%b idx=%0d oh=%h want 1/0/0001",
                     grant_valid, grant_idx, grant_onehot);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_single();
        logic [11:0] pat;
        pat = 12'b1101_1110_1111;
        do_reset();
        req = 16'h0010;
        for (int c = 0; c < 12; c++) begin
            tick();
            total_cnt++;
            if (grant_valid !== pat[c] || turnaround !== !pat[c] ||
                grant_onehot !== (pat[c] ? 16'h0010 : 16'h0000)) begin
                $display("FAIL single c=%0d got v=%b t=%b oh=%h want v=%b",
                         c, grant_valid, turnaround, grant_onehot, pat[c]);
            end else begin
                pass_cnt++;
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_idx [0:3];
        exp_idx[0] = 4'd0;
        exp_idx[1] = 4'd8;
        exp_idx[2] = 4'd15;
        exp_idx[3] = 4'd0;
        do_reset();
        req = 16'h8101;
        for (int c = 0; c < 19; c++) begin
            tick();
            total_cnt++;
            if ((c % 5) == 4) begin
                if (grant_valid !== 1'b0 || turnaround !== 1'b1 ||
                    grant_onehot !== 16'h0000) begin
                    $display("FAIL rr_gap c=%0d got v=%b t=%b oh=%h",
                             c, grant_valid, turnaround, grant_onehot);
                end else begin
                    pass_cnt++;
                end
            end else begin
                if (grant_valid !== 1'b1 || grant_idx !== exp_idx[c / 5] ||
                    grant_onehot !== (16'h0001 << exp_idx[c / 5])) begin
                    $display("FAIL rr_on c=%0d got idx=%0d oh=%h want idx=%0d",
                             c, grant_idx, grant_onehot, exp_idx[c / 5]);
                end else begin
                    pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req = 16'h0208;
        tick();
        tick();
        total_cnt++;
        if (!(grant_valid === 1'b1 && grant_idx === 4'd3)) begin
            $display("FAIL early_hold got v=%b idx=%0d want 1/3",
                     grant_valid, grant_idx);
        end else begin
            pass_cnt++;
        end
        req = 16'h0200;
        tick();
        total_cnt++;
        if (!(grant_valid === 1'b0 && turnaround === 1'b1)) begin
            $display("FAIL early_gap got v=%b t=%b want 0/1",
                     grant_valid, turnaround);
        end else begin
            pass_cnt++;
        end
        tick();
        total_cnt++;
        if (!(grant_valid === 1'b1 && grant_idx === 4'd9 &&
              grant_onehot === 16'h0200)) begin
            $display("FAIL early_next got v=%b idx=%0d oh=%h want 1/9/0200",
                     grant_valid, grant_idx, grant_onehot);
        end else begin
            pass_cnt++;
        end
        req = 16'h0000;
        tick();
        tick();
        total_cnt++;
        if (!(grant_valid === 1'b0 && turnaround === 1'b0 &&
              grant_onehot === 16'h0000)) begin
            $display("FAIL early_idle got v=%b t=%b oh=%h want idle",
                     grant_valid, turnaround, grant_onehot);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 16'h4000;
        tick();
        total_cnt++;
        if (!(grant_valid === 1'b1 && grant_idx === 4'd14)) begin
            $display("FAIL wrap_setup got v=%b idx=%0d want 1/14",
                     grant_valid, grant_idx);
        end else begin
            pass_cnt++;
        end
        req = 16'h4002;
        tick();
        tick();
        tick();
        tick();
        total_cnt++;
        if (!(turnaround === 1'b1 && grant_valid === 1'b0)) begin
            $display("FAIL wrap_gap got v=%b t=%b want 0/1",
                     grant_valid, turnaround);
        end else begin
            pass_cnt++;
        end
        tick();
        total_cnt++;
        if (!(grant_valid === 1'b1 && grant_idx === 4'd1 &&
              grant_onehot === 16'h0002)) begin
            $display("FAIL wrap_pick got v=%b idx=%0d oh=%h want 1/1/0002",
                     grant_valid, grant_idx, grant_onehot);
        end else begin
            pass_cnt++;
        end
    endtask

    initial begin
        clr = 1'b1;
        req = 16'h0000;
        test_reset();
        test_single();
        test_round_robin();
        test_early_release();
        test_wrap();
        req = 16'h0000;
        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
